// File: rtl/idex_elastic_stage.sv
// ID/EX elastic pipeline stage: valid/ready handshake, main register plus one skid entry, flush to bubble.
// Optional stall counter on stall_cnt_o when IDEX_STALL_CNT_EN is defined.
module idex_elastic_stage #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DATA_W = 169,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic                in_ready_q;
  logic                accept, drain;
  logic                main_from_in, main_from_skid, skid_from_in;

  // Flush wins: an entry offered in the flush cycle is never taken.
  assign accept = in_valid_i & in_ready_q & ~flush_i;
  assign drain  = (state_q != EMPTY) & out_ready_i;

  always_comb begin
    state_d        = state_q;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d      = ONE;
          main_from_in = 1'b1;
        end
        ONE: begin
          if (drain && accept) begin
            main_from_in = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end else if (accept) begin
            state_d      = FULL;
            skid_from_in = 1'b1;
          end
        end
        FULL: if (drain) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q    <= state_d;
      // Ready is a function of next state only, so out_ready_i never reaches in_ready_o combinationally.
      in_ready_q <= (state_d != FULL);
      if (main_from_in) begin
        main_ctrl_q <= in_ctrl_i;
        main_data_q <= in_data_i;
      end else if (main_from_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (skid_from_in) begin
        skid_ctrl_q <= in_ctrl_i;
        skid_data_q <= in_data_i;
      end
      if (flush_i) begin
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  // Bubbles carry zero control so no write enable can fire from a stale entry.
  assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
  assign out_data_o  = main_data_q;

`ifdef IDEX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= '0;
    else if (out_valid_o && !out_ready_i && !(&stall_cnt_q))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_idex_elastic_stage.sv
// Scoreboard bench for idex_elastic_stage: driver pushes expected entries, negedge monitor pops on drain.
module tb_idex_elastic_stage;
  localparam int unsigned CW = 9;
  localparam int unsigned DW = 169;
  localparam int unsigned NW = 4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [CW-1:0] in_ctrl_i = '0;
  logic [DW-1:0] in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [CW-1:0] out_ctrl_o;
  logic [DW-1:0] out_data_o;
`ifdef IDEX_STALL_CNT_EN
  logic [NW-1:0] stall_cnt_o;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic sender_done;

  idex_elastic_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ctrl_i   (in_ctrl_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ctrl_o  (out_ctrl_o),
    .out_data_o  (out_data_o)
`ifdef IDEX_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry until the stage takes it; the expected response is queued at acceptance.
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    logic acc;
    int   n;
    exp_t e;
    in_valid_i = 1'b1;
    in_ctrl_i  = c;
    in_data_i  = d;
    n = 0;
    do begin
      acc = in_ready_o && !flush_i;
      step();
      n++;
    end while (!acc && n < 50);
    if (acc) begin
      e.c = c;
      e.d = d;
      q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: data %0h not accepted in 50 cycles", d);
    end
    in_valid_i = 1'b0;
  endtask

  // Flush with a competing entry that must be discarded.
  task automatic do_flush(input logic [DW-1:0] d);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_ctrl_i  = 9'h1AA;
    in_data_i  = d;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    q.delete();
  endtask

  always @(negedge clk) begin
    if (reset && !flush_i) begin
      if (out_valid_o && out_ready_i) begin
        exp_t e;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got data %0h with nothing expected", out_data_o);
        end else begin
          e = q.pop_front();
          chk("mon_data", out_data_o, e.d);
          chk("mon_ctrl", DW'(out_ctrl_o), DW'(e.c));
        end
      end else if (!out_valid_o) begin
        chk("mon_bubble_ctrl", DW'(out_ctrl_o), '0);
      end
    end
  end

  initial begin
    int n;
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", DW'(out_valid_o), '0);
    chk("rst_ctrl", DW'(out_ctrl_o), '0);
    chk("rst_data", out_data_o, '0);
    chk("rst_ready", DW'(in_ready_o), DW'(1));
    step();
    reset = 1'b1;
    step();

    // Streaming with execute always ready
    out_ready_i = 1'b1;
    send(9'h011, 'hA); chk("t1_ready_a", DW'(in_ready_o), DW'(1));
    send(9'h022, 'hB); chk("t1_ready_b", DW'(in_ready_o), DW'(1));
    send(9'h033, 'hC); chk("t1_ready_c", DW'(in_ready_o), DW'(1));
    repeat (3) step();
    chk("t1_drained", DW'(q.size()), '0);

    // Backpressure fills main and skid; third entry waits at the producer
    out_ready_i = 1'b0;
    send(9'h001, 'h1);
    send(9'h002, 'h2);
    sender_done = 1'b0;
    fork
      begin
        send(9'h003, 'h3);
        sender_done = 1'b1;
      end
    join_none
    repeat (3) step();
    chk("t2_ready_full", DW'(in_ready_o), '0);
    chk("t2_main_data", out_data_o, 'h1);
    chk("t2_valid", DW'(out_valid_o), DW'(1));
    chk("t2_held", DW'(q.size()), DW'(2));
    out_ready_i = 1'b1;
    n = 0;
    while ((!sender_done || q.size() != 0) && n < 20) begin
      step();
      n++;
    end
    chk("t2_all_out", DW'(q.size() == 0 && sender_done), DW'(1));

    // Control visible for exactly one cycle, then zeroed bubble
    send(9'h1FF, 'h55);
    chk("t4_ctrl_on", DW'(out_ctrl_o), DW'(9'h1FF));
    chk("t4_valid_on", DW'(out_valid_o), DW'(1));
    step();
    chk("t4_ctrl_off", DW'(out_ctrl_o), '0);
    chk("t4_valid_off", DW'(out_valid_o), '0);
    chk("t4_data_hold", out_data_o, 'h55);

    // Flush from FULL with a concurrent offer
    out_ready_i = 1'b0;
    send(9'h004, 'h4);
    send(9'h005, 'h5);
    chk("t3_full", DW'(in_ready_o), '0);
    do_flush('h9);
    chk("t3_valid", DW'(out_valid_o), '0);
    chk("t3_ctrl", DW'(out_ctrl_o), '0);
    chk("t3_ready", DW'(in_ready_o), DW'(1));
    out_ready_i = 1'b1;
    repeat (4) step();
    chk("t3_still_empty", DW'(out_valid_o), '0);

    // Asynchronous reset while FULL
    out_ready_i = 1'b0;
    send(9'h006, 'h6);
    send(9'h007, 'h7);
    #2 reset = 1'b0;
    #1;
    chk("t5_valid", DW'(out_valid_o), '0);
    chk("t5_ready", DW'(in_ready_o), DW'(1));
    chk("t5_ctrl", DW'(out_ctrl_o), '0);
    chk("t5_data", out_data_o, '0);
`ifdef IDEX_STALL_CNT_EN
    chk("t5_cnt", DW'(stall_cnt_o), '0);
`endif
    q.delete();
    step();
    reset = 1'b1;
    step();

`ifdef IDEX_STALL_CNT_EN
    // Stall counter saturates and survives flush
    out_ready_i = 1'b0;
    send(9'h008, 'h8);
    repeat (20) step();
    chk("t6_cnt_sat", DW'(stall_cnt_o), DW'(4'hF));
    do_flush('hE);
    chk("t6_cnt_flush", DW'(stall_cnt_o), DW'(4'hF));
    out_ready_i = 1'b1;
    step();
`endif

    chk("end_queue_empty", DW'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
